mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LATENCY, default 4, memory access time in cycles (legal 1..15).
REQ-002 Parameter WORD_SIZE, default 16, address width.
REQ-003 The block SHALL use one clock and a reset that is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset_n  input  1  synchronous, active-high reset (1 = reset).
REQ-006 i_req  input  1  I-cache line-fill request, held until i_done.
REQ-007 i_addr  input  16  I-cache request address.
REQ-008 i_rdata  output  64  line returned to I-cache.
REQ-009 i_done  output  1  one-cycle completion pulse to I-cache.
REQ-010 d_req  input  1  D-cache request, held until d_done.
REQ-011 d_we  input  1  D-cache request is write (1) or read (0).
REQ-012 d_addr  input  16  D-cache request address.
REQ-013 d_wdata  input  64  D-cache write-back line.
REQ-014 d_rdata  output  64  line returned to D-cache.
REQ-015 d_done  output  1  one-cycle completion pulse to D-cache.
REQ-016 mem_read  output  1  memory read strobe.
REQ-017 mem_write  output  1  memory write strobe.
REQ-018 mem_addr  output  16  memory address, line aligned.
REQ-019 mem_wdata  output  64  memory write data.
REQ-020 mem_rdata  input  64  memory read data, valid in last cycle of access.

Function
REQ-021 The block SHALL be an FSM with states IDLE, BUSY, DONE.
REQ-022 IDLE: no request -> stay; any request -> grant one requester, load counter with LATENCY-1, go BUSY at next edge.
REQ-023 Arbitration SHALL be round-robin on simultaneous requests: grant the requester not granted last; after reset last-granted = I, so D wins the first tie.
REQ-024 A single pending request SHALL be granted immediately regardless of last-granted.
REQ-025 BUSY: mem_read = ~(grant_D & d_we), mem_write = grant_D & d_we, asserted every BUSY cycle; both never high together.
REQ-026 mem_addr SHALL be {addr[15:2],2'b00} of the granted requester, registered at grant and stable for all BUSY cycles.
REQ-027 mem_wdata SHALL be d_wdata registered at grant; 0 when I granted.
REQ-028 BUSY: counter decrements each cycle; at counter = 0, reads capture mem_rdata into granted requester's rdata register; go DONE.
REQ-029 DONE: pulse the granted requester's done for exactly one cycle; mem strobes low; go IDLE next edge.
REQ-030 Requests SHALL NOT be sampled in BUSY or DONE; a requester deasserting req during DONE is never regranted for that transaction.
REQ-031 Latency: req high at IDLE edge t -> strobes high cycles t+1..t+LATENCY -> done high in cycle t+LATENCY+1.
REQ-032 i_rdata/d_rdata SHALL hold their last captured value until the next read for that requester; a D write SHALL NOT modify d_rdata.
REQ-033 Back-to-back: a request still pending in IDLE after DONE SHALL be granted with no extra idle cycle beyond the IDLE cycle itself.
REQ-034 Outputs from IDLE: mem_read, mem_write, i_done, d_done = 0.

Reset
REQ-035 reset_n = 1 at a clock edge SHALL force state IDLE, counter 0, last-granted = I, all outputs 0, i_rdata = d_rdata = 0, mem_addr = mem_wdata = 0.
REQ-036 Reset asserted mid-BUSY SHALL abort the access: strobes low the following cycle, no done pulse issued.

Verification
REQ-037 Single I read, LATENCY=4, i_addr=16'h0013, mem_rdata=64'hAAAA_BBBB_CCCC_DDDD -> mem_addr=16'h0010, mem_read high 4 cycles, i_done in cycle 5, i_rdata captures value.
REQ-038 D write d_addr=16'h0042, d_wdata=64'h1234_5678_9ABC_DEF0 -> mem_write high 4 cycles, mem_addr=16'h0040, mem_read never high, d_done once, d_rdata unchanged.
REQ-039 i_req and d_req raised same cycle after reset -> D served first, I granted in IDLE cycle following d_done; next simultaneous tie -> D again after an I grant.
REQ-040 Both requesters held continuously for 6 transactions -> grants strictly alternate D,I,D,I,D,I; mem_read and mem_write never both 1.
REQ-041 reset_n pulsed in 2nd BUSY cycle of an I read -> no i_done, all outputs 0 next cycle, fresh request after reset completes normally.
REQ-042 LATENCY=1 build: I read completes with mem_read high 1 cycle and i_done in cycle 2.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: an I-cache and a D-cache share one memory port.
// Round-robin between the two on simultaneous requests; each access takes
// LATENCY strobe cycles followed by a single done cycle.
// Note: reset_n is active-high despite its name (1 = reset), synchronous.
module mem_arbiter #(
    parameter int LATENCY   = 4,
    parameter int WORD_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic [63:0]          i_rdata,
    output logic                 i_done,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [63:0]          d_wdata,
    output logic [63:0]          d_rdata,
    output logic                 d_done,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [63:0]          mem_wdata,
    input  logic [63:0]          mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0]           CNT_INIT   = 4'(LATENCY - 1);
    localparam logic [WORD_SIZE-1:0] ALIGN_MASK = ~WORD_SIZE'(3);

    state_t     state, state_nx;
    logic [3:0] cnt;
    logic       grant_d;   // current owner: 1 = D, 0 = I
    logic       gnt_we;    // current access is a D write
    logic       last_d;    // last granted requester was D
    logic       any_req;
    logic       pick_d;

    // Arbitration: a lone request wins outright; on a tie, the side not
    // granted last time wins.
    always_comb begin
        any_req = i_req | d_req;
        pick_d  = d_req & (~i_req | ~last_d);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset_n) state <= IDLE;
        else         state <= state_nx;
    end

    // Next-state and strobe/done decode.
    always_comb begin
        state_nx  = state;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        i_done    = 1'b0;
        d_done    = 1'b0;
        case (state)
            IDLE: if (any_req) state_nx = BUSY;
            BUSY: begin
                mem_read  = ~(grant_d & gnt_we);
                mem_write = grant_d & gnt_we;
                if (cnt == 4'd0) state_nx = DONE;
            end
            DONE: begin
                i_done   = ~grant_d;
                d_done   = grant_d;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Grant capture, latency counter and read-data return registers.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            cnt       <= '0;
            grant_d   <= 1'b0;
            gnt_we    <= 1'b0;
            last_d    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    grant_d   <= pick_d;
                    last_d    <= pick_d;
                    gnt_we    <= pick_d & d_we;
                    cnt       <= CNT_INIT;
                    mem_addr  <= (pick_d ? d_addr : i_addr) & ALIGN_MASK;
                    mem_wdata <= pick_d ? d_wdata : 64'd0;
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else if (!(grant_d & gnt_we)) begin
                        if (grant_d) d_rdata <= mem_rdata;
                        else         i_rdata <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
